i2c_slave: RTL and testbench
============================

// Module: i2c_slave
// PURPOSE
//  I2C slave exposing a small internal 8-bit register file to an external bus master.
//  Sits at the chip pad boundary: SCL is the only clock, SDA is sampled as data.
//  The SDA pad is open-drain and lives outside this block; SDAout requests a pull-low.
// PARAMETERS
//  SLV_ADDR  7'h50  7-bit slave address matched against the first byte after START
//  NREGS     4      number of 8-bit registers; power of 2; pointer uses low log2(NREGS) bits
// PORTS
//  SCL     in   1  bus clock; the block's single clock
//  RSTN    in   1  asynchronous active-low reset
//  SDA     in   1  bus data as seen at the pad (1 = released/high)
//  SDAout  out  1  pull-down request: 1 = drive SDA low, 0 = release
// BEHAVIOUR
//  - Reset (RSTN=0, async): SDAout=0, state=IDLE, pointer=0, all registers=8'h00.
//  - START: SDA falls while SCL=1. STOP: SDA rises while SCL=1. Each is detected by a flag
//    flop set on the SDA edge when SCL=1; the SCL-clocked FSM consumes the flag. These flags
//    are event latches, not extra clock domains.
//  - A START in any state (repeated START included) aborts the current transfer.
//    It enters ADDR with bit count 0 and SDAout=0; pointer is kept.
//  - STOP in any state -> IDLE, SDAout=0.
//  - Bits are sampled on SCL rising edge, MSB first. SDAout changes only on SCL falling edge.
//  - FSM states:
//    IDLE: waits for START.
//    ADDR: 8 bits; [7:1]==SLV_ADDR -> ACK_A, else -> IDLE.
//      A non-matching address gets no ACK; SDAout stays 0 until the next START.
//    ACK_A: SDAout=1 from the falling edge after bit 8 to the next falling edge.
//      Then R/W=0 -> REG; R/W=1 -> RDATA, loading the shift register with reg[pointer].
//    REG: 8 bits -> pointer; then ACK_R, same 1-clock ACK -> WDATA.
//    WDATA: 8 bits -> reg[pointer]. Register write occurs on the 8th rising edge.
//      Then ACK_W (ACK) and pointer increment -> WDATA.
//    RDATA: on each falling edge SDAout = ~bit (drive low for 0), MSB first.
//      After 8 bits SDAout=0 (released) -> MACK.
//    MACK: sample SDA on rising edge. 0 (ACK) -> pointer increment, reload, RDATA.
//      1 (NACK) -> IDLE with SDAout=0.
//  - Pointer increment wraps modulo NREGS (3 -> 0 for NREGS=4). Pointer bytes >= NREGS use
//    the low bits only.
//  - SDAout is never 1 during the master-driven bit phases (ADDR, REG, WDATA, MACK).
// CONFIGURATION
//  I2C_AUTOINC_EN defined: pointer increments after each written byte and each ACKed read.
//  Undefined: pointer stays fixed. Repeated writes overwrite the same register; repeated
//    reads return the same register.
// TESTING
//  1. Reset pulse with RSTN=0 for 2 time units -> SDAout=0, every register reads back 8'h00.
//  2. Write: START, 0xA0, 0x01, 0x5A, STOP -> SDAout=1 during each of the 3 ACK clocks.
//     Result: reg[1]=0x5A.
//  3. Read back: START, 0xA0, 0x01, repeated START, 0xA1, master NACK, STOP.
//     Result: SDAout bit stream on falling edges = ~0x5A = 1,0,1,0,0,1,0,1.
//  4. Wrong address: START, 0xB0, 0x00 -> no ACK; SDAout=0 throughout; registers unchanged.
//  5. Wrap, with I2C_AUTOINC_EN defined: START, 0xA0, 0x03, 0x11, 0x22, STOP.
//     Result: reg[3]=0x11, reg[0]=0x22. Without the macro, reg[3]=0x22.
//  6. Reset mid-byte: RSTN=0 during bit 4 of a data byte -> SDAout=0 immediately.
//     The next START plus address is ACKed normally.

Source files
------------

// File: rtl/i2c_slave_if.sv
// i2c_slave_if
//   Pad-level I2C data signals shared between the bus master and the slave.
//   SCL is the slave's clock and is therefore kept as a plain module port.
// Signals
//   SDA     bus data as seen at the pad (1 = released/high)
//   SDAout  slave pull-down request (1 = drive SDA low, 0 = release)
// Modports
//   slave   : input SDA, output SDAout
//   master  : output SDA, input SDAout (pad side, resolves the open-drain wire)
interface i2c_slave_if;
    logic SDA;
    logic SDAout;

    modport slave  (input  SDA, output SDAout);
    modport master (output SDA, input  SDAout);
endinterface

// File: rtl/i2c_slave.sv
// i2c_slave
//   I2C slave giving an external master access to a small 8-bit register file.
//   SCL is the only clock: bits are sampled on its rising edge and the pull-down
//   request changes only on its falling edge. START/STOP are caught by SDA-edge
//   event latches and consumed by the SCL-clocked FSM.
// Ports
//   SCL   in  bus clock
//   RSTN  in  asynchronous active-low reset
//   bus   i2c_slave_if.slave : SDA (in), SDAout (out, 1 = pull SDA low)
// Parameters
//   SLV_ADDR  7-bit address matched against the first byte after START
//   NREGS     number of 8-bit registers (power of 2, >= 2)
// Configuration macro
//   I2C_AUTOINC_EN  defined: pointer increments after each written byte and each
//                   ACKed read. Undefined: pointer stays fixed.
module i2c_slave #(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int          NREGS    = 4
) (
    input  logic        SCL,
    input  logic        RSTN,
    i2c_slave_if.slave  bus
);

    localparam int PW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_REG,
        ST_ACK_R,
        ST_WDATA,
        ST_ACK_W,
        ST_RDATA,
        ST_MACK
    } state_t;

    // START/STOP event latches: toggled on SDA edges while SCL is high; an event is
    // pending while the toggle differs from the copy last seen by the SCL FSM.
    logic          r_start_tgl;
    logic          r_stop_tgl;
    logic          r_start_seen;
    logic          r_stop_seen;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_cnt;
    logic [2:0]    w_cnt_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;
    logic [PW-1:0] w_ptr_inc;
    logic [7:0]    r_regs [NREGS];
    logic          r_sdaout;

    logic          w_start_pend;
    logic          w_stop_pend;
    logic [7:0]    w_shift_in;
    logic          w_wr_en;

    assign w_start_pend = r_start_tgl ^ r_start_seen;
    assign w_stop_pend  = r_stop_tgl  ^ r_stop_seen;
    assign w_shift_in   = {r_shift[6:0], bus.SDA};
    assign bus.SDAout   = r_sdaout;

`ifdef I2C_AUTOINC_EN
    assign w_ptr_inc = r_ptr + PW'(1);
`else
    assign w_ptr_inc = r_ptr;
`endif

    always_ff @(negedge bus.SDA or negedge RSTN) begin
        if (!RSTN)    r_start_tgl <= 1'b0;
        else if (SCL) r_start_tgl <= ~r_start_tgl;
    end

    always_ff @(posedge bus.SDA or negedge RSTN) begin
        if (!RSTN)    r_stop_tgl <= 1'b0;
        else if (SCL) r_stop_tgl <= ~r_stop_tgl;
    end

    always_ff @(posedge SCL or negedge RSTN) begin
        if (!RSTN) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_ptr        <= '0;
            r_start_seen <= 1'b0;
            r_stop_seen  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_ptr        <= w_ptr_nxt;
            r_start_seen <= r_start_tgl;
            r_stop_seen  <= r_stop_tgl;
        end
    end

    // The first rising edge after START already carries address bit 7, so a
    // pending START both enters ADDR and shifts that bit in.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_ptr_nxt   = r_ptr;
        w_wr_en     = 1'b0;
        if (w_start_pend) begin
            w_state_nxt = ST_ADDR;
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = 3'd1;
        end else if (w_stop_pend) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (w_shift_in[7:1] == SLV_ADDR) ? ST_ACK_A : ST_IDLE;
                    end
                end
                ST_ACK_A: begin
                    w_cnt_nxt = '0;
                    if (r_shift[0]) begin
                        w_state_nxt = ST_RDATA;
                        w_shift_nxt = r_regs[r_ptr];
                    end else begin
                        w_state_nxt = ST_REG;
                    end
                end
                ST_REG: begin
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_ptr_nxt   = w_shift_in[PW-1:0];
                        w_state_nxt = ST_ACK_R;
                    end
                end
                ST_ACK_R: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WDATA;
                end
                ST_WDATA: begin
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_wr_en     = 1'b1;
                        w_state_nxt = ST_ACK_W;
                    end
                end
                ST_ACK_W: begin
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = w_ptr_inc;
                    w_state_nxt = ST_WDATA;
                end
                ST_RDATA: begin
                    w_cnt_nxt = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) w_state_nxt = ST_MACK;
                end
                ST_MACK: begin
                    w_cnt_nxt = '0;
                    if (!bus.SDA) begin
                        w_ptr_nxt   = w_ptr_inc;
                        w_shift_nxt = r_regs[w_ptr_inc];
                        w_state_nxt = ST_RDATA;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge SCL or negedge RSTN) begin
        if (!RSTN) begin
            for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[r_ptr] <= w_shift_in;
        end
    end

    // Pull-down request, updated while SCL is low. During a read, r_cnt counts
    // bits already clocked out, so ~r_cnt indexes the next bit MSB-first.
    always_ff @(negedge SCL or negedge RSTN) begin
        if (!RSTN) begin
            r_sdaout <= 1'b0;
        end else if (w_start_pend || w_stop_pend) begin
            r_sdaout <= 1'b0;
        end else begin
            case (r_state)
                ST_ACK_A, ST_ACK_R, ST_ACK_W: r_sdaout <= 1'b1;
                ST_RDATA:                     r_sdaout <= ~r_shift[~r_cnt];
                default:                      r_sdaout <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave
//   Bench for i2c_slave. A master model generates SCL/SDA; for every SCL clock it
//   pushes the pull-down level the slave should present into a queue. A monitor
//   pops one entry per SCL rising edge and compares it with SDAout.
module tb_i2c_slave;

    typedef struct {
        string tag;
        logic  exp;
    } exp_t;

    logic SCL  = 1'b1;
    logic RSTN = 1'b0;
    logic m_sda = 1'b1;
    logic mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    i2c_slave_if bus ();
    assign bus.SDA = m_sda & ~bus.SDAout;

    i2c_slave #(.SLV_ADDR(7'h50), .NREGS(4)) dut (
        .SCL  (SCL),
        .RSTN (RSTN),
        .bus  (bus)
    );

`ifdef I2C_AUTOINC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    task automatic check(input string tag, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: SDAout=%b expected %b at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input string tag, input logic exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge SCL);
            #1;
            if (mon_en) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_clock: SDAout=%b expected no clock at %0t", bus.SDAout, $time);
                end else begin
                    e = q.pop_front();
                    check(e.tag, bus.SDAout, e.exp);
                end
            end
        end
    end

    // SCL is low on entry and exit of every bit-level task except START/STOP.
    task automatic clk_bit(input logic b, input logic exp, input string tag);
        #1 m_sda = b;
        #1 push(tag, exp);
        #3 SCL = 1'b1;
        #5 SCL = 1'b0;
    endtask

    task automatic start_c();
        m_sda = 1'b0;
        #5 SCL = 1'b0;
    endtask

    task automatic rep_start();
        #1 m_sda = 1'b1;
        #1 push("rstart", 1'b0);
        #3 SCL = 1'b1;
        #3 m_sda = 1'b0;
        #2 SCL = 1'b0;
    endtask

    task automatic stop_c();
        #1 m_sda = 1'b0;
        #1 push("stop", 1'b0);
        #3 SCL = 1'b1;
        #3 m_sda = 1'b1;
        #5;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic ack, input string tag);
        for (int i = 7; i >= 0; i--) clk_bit(d[i], 1'b0, tag);
        clk_bit(1'b1, ack, {tag, "_ack"});
    endtask

    task automatic read_byte(input logic [7:0] d, input logic mack, input string tag);
        for (int i = 7; i >= 0; i--) clk_bit(1'b1, ~d[i], $sformatf("%s_b%0d", tag, i));
        clk_bit(~mack, 1'b0, {tag, "_mack"});
    endtask

    task automatic read_reg(input logic [7:0] p, input logic [7:0] d, input string tag);
        start_c();
        send_byte(8'hA0, 1'b1, {tag, "_aw"});
        send_byte(p, 1'b1, {tag, "_ptr"});
        rep_start();
        send_byte(8'hA1, 1'b1, {tag, "_ar"});
        read_byte(d, 1'b0, tag);
        stop_c();
    endtask

    initial begin
        // Reset pulse
        #1 check("reset_during", bus.SDAout, 1'b0);
        #1 RSTN = 1'b1;
        #2 check("reset_after", bus.SDAout, 1'b0);
        mon_en = 1'b1;
        #5;
        for (int r = 0; r < 4; r++) read_reg(8'(r), 8'h00, $sformatf("rst_r%0d", r));

        // Write 0x5A to reg 1, read it back
        start_c();
        send_byte(8'hA0, 1'b1, "wr_addr");
        send_byte(8'h01, 1'b1, "wr_ptr");
        send_byte(8'h5A, 1'b1, "wr_data");
        stop_c();
        read_reg(8'h01, 8'h5A, "rd_r1");

        // Wrong address: never acknowledged, registers untouched
        start_c();
        send_byte(8'hB0, 1'b0, "bad_addr");
        send_byte(8'h00, 1'b0, "bad_byte");
        stop_c();
        read_reg(8'h01, 8'h5A, "bad_r1");
        read_reg(8'h00, 8'h00, "bad_r0");

        // Two-byte write starting at reg 3
        start_c();
        send_byte(8'hA0, 1'b1, "wrap_addr");
        send_byte(8'h03, 1'b1, "wrap_ptr");
        send_byte(8'h11, 1'b1, "wrap_d0");
        send_byte(8'h22, 1'b1, "wrap_d1");
        stop_c();
        read_reg(8'h03, AUTO ? 8'h11 : 8'h22, "wrap_r3");
        read_reg(8'h00, AUTO ? 8'h22 : 8'h00, "wrap_r0");

        // Two-byte read from reg 0 (master ACKs the first byte), pointer byte 0x04 uses low bits
        start_c();
        send_byte(8'hA0, 1'b1, "burst_aw");
        send_byte(8'h04, 1'b1, "burst_ptr");
        rep_start();
        send_byte(8'hA1, 1'b1, "burst_ar");
        read_byte(AUTO ? 8'h22 : 8'h00, 1'b1, "burst_b0");
        read_byte(AUTO ? 8'h5A : 8'h00, 1'b0, "burst_b1");
        stop_c();

        // Reset while the slave is driving bit 4 of a read byte (reg 2 = 0x00 -> all pulled low)
        start_c();
        send_byte(8'hA0, 1'b1, "mid_aw");
        send_byte(8'h02, 1'b1, "mid_ptr");
        rep_start();
        send_byte(8'hA1, 1'b1, "mid_ar");
        for (int i = 0; i < 3; i++) clk_bit(1'b1, 1'b1, $sformatf("mid_b%0d", 7 - i));
        #1 check("mid_driving", bus.SDAout, 1'b1);
        RSTN = 1'b0;
        #1 check("mid_reset", bus.SDAout, 1'b0);
        #1 RSTN = 1'b1;
        #1;
        rep_start();
        send_byte(8'hA0, 1'b1, "post_aw");
        send_byte(8'h01, 1'b1, "post_ptr");
        rep_start();
        send_byte(8'hA1, 1'b1, "post_ar");
        read_byte(8'h00, 1'b0, "post_r1");
        stop_c();

        #20;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
